// File: rtl/fft_bundle_packer.sv
// Serial-to-parallel I/Q packer feeding an FFT butterfly stage.
// Samples are gathered into DEPTH-lane bundles held in a ping/pong pair of
// buffers; a bundle closes on its DEPTH-th sample or early on s_last, in
// which case the lanes that were never written read as zero.
// Optional build macro: FFT_BUNDLE_BITREV_EN places the k-th sample in lane
// bitreverse(k) for decimation-in-time ordering; natural order otherwise.
module fft_bundle_packer #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic signed [WIDTH-1:0] s_R,
  input  logic signed [WIDTH-1:0] s_Q,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic signed [WIDTH-1:0] dout_R [DEPTH],
  output logic signed [WIDTH-1:0] dout_Q [DEPTH]
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] CntMax = AW'(DEPTH - 1);

  logic signed [WIDTH-1:0] buf_r_q [2][DEPTH];
  logic signed [WIDTH-1:0] buf_i_q [2][DEPTH];
  logic [1:0]    full_q, full_d;
  logic [1:0]    last_q, last_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;

  logic          accept;
  logic          close;
  logic          pop;
  logic [AW-1:0] lane;

`ifdef FFT_BUNDLE_BITREV_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < int'(AW); i++) begin
      r[i] = v[AW-1-i];
    end
    return r;
  endfunction

  assign lane = bitrev(cnt_q);
`else
  assign lane = cnt_q;
`endif

  // Handshake decode; ready depends only on registered state.
  assign s_ready = ~full_q[wr_ptr_q];
  assign accept  = s_valid & s_ready;
  assign close   = accept & ((cnt_q == CntMax) | s_last);
  assign pop     = full_q[rd_ptr_q] & m_ready;

  // Lane storage: the first sample of a bundle also zeroes every other lane,
  // so lanes skipped by an early s_last closure come out as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < int'(DEPTH); l++) begin
          buf_r_q[b][l] <= '0;
          buf_i_q[b][l] <= '0;
        end
      end
    end else if (accept) begin
      for (int l = 0; l < int'(DEPTH); l++) begin
        if (AW'(l) == lane) begin
          buf_r_q[wr_ptr_q][l] <= s_R;
          buf_i_q[wr_ptr_q][l] <= s_Q;
        end else if (cnt_q == '0) begin
          buf_r_q[wr_ptr_q][l] <= '0;
          buf_i_q[wr_ptr_q][l] <= '0;
        end
      end
    end
  end

  // Next-state for fill counter, pointers and per-buffer flags. Closure
  // targets the write buffer (never full) and pop the read buffer (always
  // full), so the two never touch the same flag bit in one cycle.
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    full_d   = full_q;
    last_d   = last_q;
    if (accept) begin
      if (close) begin
        cnt_d            = '0;
        wr_ptr_d         = ~wr_ptr_q;
        full_d[wr_ptr_q] = 1'b1;
        last_d[wr_ptr_q] = s_last;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (pop) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      full_q   <= '0;
      last_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      last_q   <= last_d;
    end
  end

  // Present the read buffer.
  always_comb begin
    m_valid = full_q[rd_ptr_q];
    m_last  = last_q[rd_ptr_q];
    for (int l = 0; l < int'(DEPTH); l++) begin
      dout_R[l] = buf_r_q[rd_ptr_q][l];
      dout_Q[l] = buf_i_q[rd_ptr_q][l];
    end
  end

endmodule

// File: tb/tb_fft_bundle_packer.sv
// Scoreboard bench for fft_bundle_packer: a sample-list model builds each
// expected bundle when it closes; a monitor checks every presented bundle,
// the valid/ready flags each cycle, and pops on the output handshake.
module tb_fft_bundle_packer;

  localparam int unsigned W  = 9;
  localparam int unsigned D  = 16;
  localparam int unsigned AW = $clog2(D);

  typedef logic signed [W-1:0] samp_t;
  typedef struct {
    samp_t r [D];
    samp_t q [D];
    logic  last;
  } bundle_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  s_valid = 1'b0;
  logic  s_last = 1'b0;
  logic  m_ready = 1'b0;
  samp_t s_R = '0;
  samp_t s_Q = '0;
  logic  s_ready, m_valid, m_last;
  samp_t dout_R [D];
  samp_t dout_Q [D];

  int errors = 0;
  int checks = 0;
  int pushed = 0;
  int popped = 0;

  bundle_t exp_q [$];
  samp_t   cur_r [$];
  samp_t   cur_q [$];

  fft_bundle_packer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_R     (s_R),
    .s_Q     (s_Q),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .dout_R  (dout_R),
    .dout_Q  (dout_Q)
  );

  always #5 clk = ~clk;

  function automatic int lane_of(int k);
`ifdef FFT_BUNDLE_BITREV_EN
    int r = 0;
    for (int b = 0; b < int'(AW); b++) begin
      if (((k >> b) & 1) != 0) r = r | (1 << (int'(AW) - 1 - b));
    end
    return r;
`else
    return k;
`endif
  endfunction

  // Reference model: collect accepted samples, build the bundle on closure.
  always begin
    bundle_t b;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      pushed = pushed - exp_q.size();
      cur_r.delete();
      cur_q.delete();
      exp_q.delete();
    end else if (s_valid && s_ready) begin
      cur_r.push_back(s_R);
      cur_q.push_back(s_Q);
      if (cur_r.size() == D || s_last) begin
        for (int l = 0; l < int'(D); l++) begin
          b.r[l] = '0;
          b.q[l] = '0;
        end
        for (int k = 0; k < cur_r.size(); k++) begin
          b.r[lane_of(k)] = cur_r[k];
          b.q[lane_of(k)] = cur_q[k];
        end
        b.last = s_last;
        exp_q.push_back(b);
        pushed++;
        cur_r.delete();
        cur_q.delete();
      end
    end
  end

  // Monitor: flags every cycle, bundle contents whenever presented.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (m_valid !== (exp_q.size() > 0)) begin
        errors++;
        $display("FAIL m_valid: got %0b want %0b", m_valid, exp_q.size() > 0);
      end
      checks++;
      if (s_ready !== (exp_q.size() < 2)) begin
        errors++;
        $display("FAIL s_ready: got %0b want %0b", s_ready, exp_q.size() < 2);
      end
      if (m_valid && exp_q.size() > 0) begin
        int bad = -1;
        for (int l = 0; l < int'(D); l++) begin
          if (bad < 0 && (dout_R[l] !== exp_q[0].r[l] || dout_Q[l] !== exp_q[0].q[l])) bad = l;
        end
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL bundle lane %0d: got R=%0d Q=%0d want R=%0d Q=%0d", bad,
                   dout_R[bad], dout_Q[bad], exp_q[0].r[bad], exp_q[0].q[bad]);
        end
        checks++;
        if (m_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL m_last: got %0b want %0b", m_last, exp_q[0].last);
        end
        if (m_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Offer one sample and hold it until accepted (bounded wait).
  task automatic send(input samp_t r, input samp_t q, input logic last);
    logic acc = 1'b0;
    int   waited = 0;
    s_valid = 1'b1;
    s_R     = r;
    s_Q     = q;
    s_last  = last;
    while (!acc && waited < 200) begin
      @(negedge clk);
      acc = s_ready;
      step();
      waited++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_ready=0 for %0d cycles want acceptance", waited);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic done;
    int   nz;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;

    // Post-reset output state.
    @(negedge clk);
    nz = 0;
    for (int l = 0; l < int'(D); l++) if (dout_R[l] !== '0 || dout_Q[l] !== '0) nz++;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_last !== 1'b0 || nz != 0) begin
      errors++;
      $display("FAIL reset_state: got s_ready=%0b m_valid=%0b m_last=%0b nonzero_lanes=%0d want 1 0 0 0",
               s_ready, m_valid, m_last, nz);
    end
    step();

    // Full bundle, R=k Q=-k.
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) send(samp_t'(k), samp_t'(-k), 1'b0);
    idle(2);

    // Short frame closed by s_last.
    for (int k = 1; k <= 5; k++) send(samp_t'(k), samp_t'(-k), k == 5);
    idle(2);

    // Back-pressure: both buffers fill, then drain in order.
    m_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 48; k++) send(samp_t'(k + 20), samp_t'(3 * k), 1'b0);
      end
      begin
        idle(45);
        m_ready = 1'b1;
      end
    join
    idle(20);

    // Sustained throughput.
    m_ready = 1'b1;
    for (int k = 0; k < 64; k++) send(samp_t'($urandom), samp_t'($urandom), 1'b0);
    idle(3);

    // Reset mid-bundle discards the partial fill.
    for (int k = 0; k < 7; k++) send(samp_t'(100 + k), samp_t'(k), 1'b0);
    pulse_reset();
    for (int k = 0; k < 16; k++) send(samp_t'(-k), samp_t'(50 + k), 1'b0);
    idle(3);

    // Randomized traffic with random back-pressure and early closures.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(samp_t'($urandom), samp_t'($urandom), $urandom_range(0, 15) == 0);
          idle($urandom_range(0, 2));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          step();
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    // Close any partial bundle, then drain.
    send(samp_t'(7), samp_t'(-7), 1'b1);
    m_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
    idle(2);
    checks++;
    if (exp_q.size() != 0 || pushed != popped) begin
      errors++;
      $display("FAIL drain: got pending=%0d popped=%0d want pending=0 popped=%0d",
               exp_q.size(), popped, pushed);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_bundle_packer.md
FFT_BUNDLE_PACKER -- requirements
Module: fft_bundle_packer

Interface
REQ-001 SHALL have parameter WIDTH, default 9, signed sample width per I/Q component.
REQ-002 SHALL have parameter DEPTH, default 16, lanes per bundle; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  serial sample present.
REQ-006 SHALL have port s_ready  output  1  packer can accept a sample this cycle.
REQ-007 SHALL have port s_last  input  1  qualifies the accepted sample as the final sample of a frame.
REQ-008 SHALL have port s_R  input  WIDTH signed  in-phase sample.
REQ-009 SHALL have port s_Q  input  WIDTH signed  quadrature sample.
REQ-010 SHALL have port m_valid  output  1  complete bundle presented on dout_R/dout_Q.
REQ-011 SHALL have port m_ready  input  1  downstream butterfly stage consumes the bundle.
REQ-012 SHALL have port m_last  output  1  presented bundle was closed by s_last.
REQ-013 SHALL have port dout_R  output  DEPTH x WIDTH signed unpacked array  in-phase lanes, lane 0 first.
REQ-014 SHALL have port dout_Q  output  DEPTH x WIDTH signed unpacked array  quadrature lanes.

Function
REQ-015 SHALL accept a sample only on a cycle where s_valid and s_ready are both 1.
REQ-016 SHALL hold two bundle buffers (ping/pong), each with a full flag; the write pointer selects the filling buffer, the read pointer selects the presented buffer.
REQ-017 SHALL drive s_ready = 1 exactly when the write buffer is not full; s_ready is combinational from registered state only and never depends on s_valid.
REQ-018 SHALL write the k-th accepted sample of a bundle (fill counter k, 0..DEPTH-1) to lane k of the write buffer, R and Q alike, with no width change.
REQ-019 SHALL close the bundle when the accepted sample has k = DEPTH-1 or s_last = 1: set full flag, record last flag = s_last, reset k to 0, toggle write pointer.
REQ-020 SHALL force every lane not written before an s_last closure to 0 in the closed bundle.
REQ-021 SHALL drive m_valid = full flag of the read buffer, m_last = its last flag, dout = its lanes; m_valid first high the cycle after the closing sample is accepted (latency 1).
REQ-022 SHALL, on m_valid and m_ready, clear that buffer's full flag and toggle the read pointer; dout/m_last SHALL stay stable while m_valid = 1 and m_ready = 0.
REQ-023 SHALL perform a closure and a pop in the same cycle independently, sustaining one sample per cycle with continuous m_ready.
REQ-024 SHALL deassert s_ready when both buffers are full; s_valid while s_ready = 0 is ignored.
REQ-025 SHALL treat s_last on a sample with k = DEPTH-1 as a normal full closure with last flag 1 (no extra padded bundle).

Reset
REQ-026 SHALL, while rst_n = 0 at a rising clk edge, clear both buffers to 0, both full and last flags, fill counter, and both pointers.
REQ-027 SHALL hold outputs after reset at: s_ready 1, m_valid 0, m_last 0, all dout lanes 0.
REQ-028 SHALL discard a partially filled bundle and any unconsumed bundles on reset mid-operation; no output appears afterwards until DEPTH new samples or s_last.

Configuration
REQ-029 SHALL, when macro FFT_BUNDLE_BITREV_EN is defined, write the k-th sample to lane bitreverse(k) over log2(DEPTH) bits, feeding decimation-in-time ordering.
REQ-030 SHALL, when FFT_BUNDLE_BITREV_EN is undefined, use natural lane order per REQ-018; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset then R=k,Q=-k for k=0..15 with m_ready=1 -> one cycle after 16th accept m_valid=1, dout_R[k]=k, dout_Q[k]=-k, m_last=0.
REQ-032 SHALL cover: 5 samples R=1..5, s_last on 5th -> m_valid=1, m_last=1, dout_R[0..4]=1..5, lanes 5..15 = 0.
REQ-033 SHALL cover: m_ready=0, 48 back-to-back samples offered -> s_ready drops after 32nd accept, two bundles later delivered in order, no sample lost.
REQ-034 SHALL cover: continuous valid and m_ready=1 for 64 samples -> s_ready never 0, four bundles on consecutive 16-cycle periods.
REQ-035 SHALL cover: rst_n=0 for one cycle after 7 samples -> m_valid stays 0 until 16 further samples accepted; first bundle holds only post-reset data.
REQ-036 SHALL cover, with FFT_BUNDLE_BITREV_EN: R=k for k=0..15 -> dout_R[1]=8, dout_R[2]=4, dout_R[3]=12, dout_R[15]=15.
